barrett_share_ctrl: RTL

- Controller that shares one fixed-latency pipelined Barrett reducer (96-bit X, 48-bit q, 53-bit mu, 49-bit r) among N requesters, e.g. the NTT butterfly lanes.
- Holds the modulus configuration (q, mu) and allows it to change only once the reducer pipeline has drained.
- Arbitrates requests round-robin, tracks in-flight IDs for LAT cycles, and routes each result back to its requester.

---
 rtl/barrett_share_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/barrett_share_ctrl.sv
// barrett_share_ctrl: shares one fixed-latency pipelined Barrett reducer among N requesters.
//
// Holds the active modulus (q, mu). A new configuration is accepted only once the reducer
// pipeline is empty. Requests are arbitrated round-robin and issued one per cycle. Each
// issued lane ID travels down a tag pipe alongside the reducer, so that the result can be
// routed back to the requester that issued it.
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   cfg_valid/q/mu/ready   modulus configuration handshake
//   req_valid/x/ready      per-lane operand requests; req_ready is a one-hot grant
//   red_valid/x/q/mu       operand and active modulus driven to the reducer
//   red_r                  reducer result, LAT cycles after red_valid
//   rsp_valid/rsp_r        one-hot result strobe and result value (LAT+2 after the grant)
//   busy                   work pending, or not in the run state
//
// Build option: define BARRETT_SHARE_FINAL_SUB_EN to apply a final conditional subtraction
// of q to red_r before the response register.

module barrett_share_ctrl #(
    parameter int unsigned N   = 4,
    parameter int unsigned LAT = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cfg_valid,
    input  logic [47:0]       cfg_q,
    input  logic [52:0]       cfg_mu,
    output logic              cfg_ready,
    input  logic [N-1:0]      req_valid,
    input  logic [N*96-1:0]   req_x,
    output logic [N-1:0]      req_ready,
    output logic              red_valid,
    output logic [95:0]       red_x,
    output logic [47:0]       red_q,
    output logic [52:0]       red_mu,
    input  logic [48:0]       red_r,
    output logic [N-1:0]      rsp_valid,
    output logic [48:0]       rsp_r,
    output logic              busy
);

    localparam int unsigned IdW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IdxW = IdW + 1;
    localparam int unsigned InfW = $clog2(LAT + 3);

    typedef enum logic [1:0] {StUncfg, StRun, StDrain} state_e;

    state_e                  state_q, state_d;
    logic [47:0]             q_q, q_d;
    logic [52:0]             mu_q, mu_d;
    logic [IdW-1:0]          ptr_q, ptr_d;
    logic                    red_valid_q, red_valid_d;
    logic [95:0]             red_x_q, red_x_d;
    logic [IdW-1:0]          red_id_q, red_id_d;
    logic [LAT-1:0]          tag_vld_q, tag_vld_d;
    logic [LAT-1:0][IdW-1:0] tag_id_q, tag_id_d;
    logic [N-1:0]            rsp_valid_q, rsp_valid_d;
    logic [48:0]             rsp_r_q, rsp_r_d;
    logic [InfW-1:0]         inflight_q, inflight_d;

    logic [N-1:0][95:0]      req_x_lanes;
    logic                    gnt_found;
    logic [IdW-1:0]          gnt_id;
    logic [IdxW-1:0]         scan_idx;
    logic                    grant;
    logic                    cfg_rdy;
    logic                    cfg_hs;
    logic                    drained;
    logic [48:0]             r_fixed;

    assign req_x_lanes = req_x;

    // First requesting lane at or after the pointer, wrapping modulo N.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_idx = IdxW'(ptr_q) + IdxW'(k);
            if (scan_idx >= IdxW'(N)) begin
                scan_idx = scan_idx - IdxW'(N);
            end
            if (!gnt_found && req_valid[scan_idx[IdW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = scan_idx[IdW-1:0];
            end
        end
    end

    assign grant = (state_q == StRun) && gnt_found;

    // An operand sitting in the issue register is not yet counted in inflight_q but is
    // already committed to the reducer, so it also blocks reconfiguration.
    assign drained = (inflight_q == '0) && !red_valid_q;

    always_comb begin
        cfg_rdy = 1'b0;
        unique case (state_q)
            StUncfg: cfg_rdy = 1'b1;
            StRun:   cfg_rdy = 1'b0;
            StDrain: cfg_rdy = drained;
            default: cfg_rdy = 1'b0;
        endcase
    end

    assign cfg_hs = cfg_valid && cfg_rdy;

    // Configuration FSM.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        mu_d    = mu_q;
        unique case (state_q)
            StUncfg: if (cfg_hs) state_d = StRun;
            StRun:   if (cfg_valid) state_d = StDrain;
            StDrain: if (cfg_hs) state_d = StRun;
            default: state_d = StUncfg;
        endcase
        if (cfg_hs) begin
            q_d  = cfg_q;
            mu_d = cfg_mu;
        end
    end

    // Issue stage and round-robin pointer.
    always_comb begin
        red_valid_d = grant;
        red_id_d    = gnt_id;
        red_x_d     = grant ? req_x_lanes[gnt_id] : red_x_q;
        ptr_d       = ptr_q;
        if (grant) begin
            ptr_d = (gnt_id == IdW'(N - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    // Tag pipe: stage LAT-1 lines up with red_r for the matching operand.
    always_comb begin
        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = red_valid_q;
        tag_id_d[0]  = red_id_q;
        for (int unsigned i = 1; i < LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

`ifdef BARRETT_SHARE_FINAL_SUB_EN
    assign r_fixed = (red_r >= {1'b0, q_q}) ? red_r - {1'b0, q_q} : red_r;
`else
    assign r_fixed = red_r;
`endif

    always_comb begin
        rsp_valid_d = '0;
        rsp_r_d     = '0;
        if (tag_vld_q[LAT-1]) begin
            rsp_valid_d = N'(1) << tag_id_q[LAT-1];
            rsp_r_d     = r_fixed;
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (red_valid_q && !(|rsp_valid_q)) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!red_valid_q && (|rsp_valid_q)) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StUncfg;
            q_q         <= '0;
            mu_q        <= '0;
            ptr_q       <= '0;
            red_valid_q <= 1'b0;
            red_x_q     <= '0;
            red_id_q    <= '0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_r_q     <= '0;
            inflight_q  <= '0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            mu_q        <= mu_d;
            ptr_q       <= ptr_d;
            red_valid_q <= red_valid_d;
            red_x_q     <= red_x_d;
            red_id_q    <= red_id_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_r_q     <= rsp_r_d;
            inflight_q  <= inflight_d;
        end
    end

    assign req_ready = grant ? (N'(1) << gnt_id) : '0;
    // Gated so that every output reads 0 while reset is held.
    assign cfg_ready = rstn && cfg_rdy;
    assign busy      = rstn && ((state_q != StRun) || (inflight_q != '0) || red_valid_q);
    assign red_valid = red_valid_q;
    assign red_x     = red_x_q;
    assign red_q     = q_q;
    assign red_mu    = mu_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_r     = rsp_r_q;

endmodule
